// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that funnels byte requests from NUM_REQ clients into one UART transmitter.
// Define UART_TX_ARB_TAG_EN to prefix each granted byte with a tag byte 0xA0 | requester index.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       i_Clock,
  input  logic                       i_Rst_L,
  input  logic [NUM_REQ-1:0]         i_Req,
  input  logic [8*NUM_REQ-1:0]       i_Req_Byte,
  output logic [NUM_REQ-1:0]         o_Ack,
  output logic                       o_TX_DV,
  output logic [7:0]                 o_TX_Byte,
  input  logic                       i_TX_Active,
  input  logic                       i_TX_Done,
  output logic [$clog2(NUM_REQ)-1:0] o_Grant_Id,
  output logic                       o_Busy
);

  localparam int          IDW    = $clog2(NUM_REQ);
  localparam int unsigned NREQ_U = NUM_REQ;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
`ifdef UART_TX_ARB_TAG_EN
    SEND_TAG  = 3'd1,
    WAIT_TAG  = 3'd2,
`endif
    SEND_DATA = 3'd3,
    WAIT_DATA = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   prio_q, prio_d;
  logic [7:0]       byte_q, byte_d;
  logic [NUM_REQ-1:0] ack_d;
  logic             dv_d;
  logic [7:0]       txb_d;
  logic [IDW-1:0]   gid_d;
  logic             busy_d;

  logic             req_hit;
  logic [IDW-1:0]   req_idx;
  logic [IDW-1:0]   prio_next;
  logic [7:0]       req_byte;

  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int unsigned ofs);
    int unsigned sum;
    sum = 32'(base) + ofs;
    if (sum >= NREQ_U) sum = sum - NREQ_U;
    return IDW'(sum);
  endfunction

  // First requester found walking upward from prio_q, wrapping past NUM_REQ-1.
  always_comb begin
    req_hit = 1'b0;
    req_idx = '0;
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      if (!req_hit && i_Req[rr_index(prio_q, i)]) begin
        req_hit = 1'b1;
        req_idx = rr_index(prio_q, i);
      end
    end
  end

  assign prio_next = (req_idx == IDW'(NUM_REQ - 1)) ? '0 : req_idx + 1'b1;
  assign req_byte  = i_Req_Byte[{req_idx, 3'b000} +: 8];

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // All outputs are registered; the combinational block computes their next values.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    byte_d  = byte_q;
    ack_d   = '0;
    dv_d    = 1'b0;
    txb_d   = o_TX_Byte;
    gid_d   = o_Grant_Id;
    busy_d  = o_Busy;
    case (state_q)
      IDLE: begin
        if (req_hit && !i_TX_Active) begin
          byte_d         = req_byte;
          gid_d          = req_idx;
          busy_d         = 1'b1;
          ack_d[req_idx] = 1'b1;
          prio_d         = prio_next;
`ifdef UART_TX_ARB_TAG_EN
          state_d        = SEND_TAG;
`else
          state_d        = SEND_DATA;
`endif
        end
      end
`ifdef UART_TX_ARB_TAG_EN
      SEND_TAG: begin
        dv_d    = 1'b1;
        txb_d   = 8'hA0 | 8'(o_Grant_Id);
        state_d = WAIT_TAG;
      end
      WAIT_TAG: begin
        if (i_TX_Done) state_d = SEND_DATA;
      end
`endif
      SEND_DATA: begin
        dv_d    = 1'b1;
        txb_d   = byte_q;
        state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (i_TX_Done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      prio_q     <= '0;
      byte_q     <= '0;
      o_Ack      <= '0;
      o_TX_DV    <= 1'b0;
      o_TX_Byte  <= '0;
      o_Grant_Id <= '0;
      o_Busy     <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      byte_q     <= byte_d;
      o_Ack      <= ack_d;
      o_TX_DV    <= dv_d;
      o_TX_Byte  <= txb_d;
      o_Grant_Id <= gid_d;
      o_Busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: table vectors, directed corner sequences and
// random traffic against a transaction-level model plus a simple transmitter model.
module tb_uart_tx_arbiter;

  localparam int N = 4;
`ifdef UART_TX_ARB_TAG_EN
  localparam bit TAG = 1'b1;
`else
  localparam bit TAG = 1'b0;
`endif

  logic           i_Clock = 1'b0;
  logic           i_Rst_L;
  logic [N-1:0]   i_Req;
  logic [8*N-1:0] i_Req_Byte;
  logic [N-1:0]   o_Ack;
  logic           o_TX_DV;
  logic [7:0]     o_TX_Byte;
  logic           i_TX_Active;
  logic           i_TX_Done;
  logic [1:0]     o_Grant_Id;
  logic           o_Busy;

  always #5 i_Clock = ~i_Clock;

  uart_tx_arbiter #(.NUM_REQ(N)) dut (
    .i_Clock    (i_Clock),
    .i_Rst_L    (i_Rst_L),
    .i_Req      (i_Req),
    .i_Req_Byte (i_Req_Byte),
    .o_Ack      (o_Ack),
    .o_TX_DV    (o_TX_DV),
    .o_TX_Byte  (o_TX_Byte),
    .i_TX_Active(i_TX_Active),
    .i_TX_Done  (i_TX_Done),
    .o_Grant_Id (o_Grant_Id),
    .o_Busy     (o_Busy)
  );

  int checks;
  int errors;
  int cyc;

  // Transaction-level reference: one free/busy flag, a rotating priority pointer,
  // and a queue of bytes the transmitter must receive in order.
  bit         m_free;
  int         m_prio;
  logic [3:0] m_ack;
  logic [1:0] m_gid;
  bit         m_busy;
  int         m_dones;
  int         m_dv_due;
  logic [7:0] m_txq[$];

  int         ack_log[$];
  logic [7:0] dv_log[$];
  int         tx_cnt;
  bit         hold_active;
  bit         prev_ack;
  bit         prev_dv;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] bytes;
    logic [3:0]  exp_ack;
    logic [1:0]  exp_gid;
    logic [7:0]  exp_byte;
  } vec_t;
  vec_t tv[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_free   = 1'b1;
    m_prio   = 0;
    m_ack    = '0;
    m_gid    = '0;
    m_busy   = 1'b0;
    m_dones  = 0;
    m_dv_due = -1;
    m_txq.delete();
    tx_cnt   = 0;
    prev_ack = 1'b0;
    prev_dv  = 1'b0;
  endtask

  task automatic model_edge();
    m_ack = '0;
    if (m_free) begin
      if (!i_TX_Active && i_Req != '0) begin
        int k;
        k = 0;
        for (int i = 0; i < N; i++) begin
          int j;
          j = (m_prio + i) % N;
          if (i_Req[j]) begin
            k = j;
            break;
          end
        end
        m_ack    = 4'(1 << k);
        m_gid    = 2'(k);
        m_busy   = 1'b1;
        m_free   = 1'b0;
        m_prio   = (k + 1) % N;
        m_dones  = TAG ? 2 : 1;
        m_dv_due = cyc + 2;
        if (TAG) m_txq.push_back(8'hA0 | 8'(k));
        m_txq.push_back(i_Req_Byte[8*k +: 8]);
      end
    end else if (i_TX_Done) begin
      m_dones--;
      if (m_dones == 0) begin
        m_free = 1'b1;
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("ack", o_Ack, m_ack);
    chk("busy", o_Busy, m_busy);
    chk("grant_id", o_Grant_Id, m_gid);
    if (m_dv_due == cyc) chk("dv_latency", o_TX_DV, 1);
    if (o_TX_DV) begin
      if (m_txq.size() == 0) chk("dv_unexpected", o_TX_DV, 0);
      else chk("tx_byte", o_TX_Byte, m_txq.pop_front());
      chk("dv_while_tx_busy", 32'(tx_cnt), 0);
      dv_log.push_back(o_TX_Byte);
    end
    if (prev_dv) chk("dv_back_to_back", o_TX_DV, 0);
    if (prev_ack) chk("ack_back_to_back", |o_Ack, 0);
    for (int k = 0; k < N; k++) if (o_Ack[k]) ack_log.push_back(k);
    prev_ack = |o_Ack;
    prev_dv  = o_TX_DV;
  endtask

  // Transmitter: busy for 1..4 cycles after each load, then a one-cycle done pulse.
  task automatic tx_model();
    i_TX_Done = 1'b0;
    if (o_TX_DV) tx_cnt = $urandom_range(1, 4);
    else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) i_TX_Done = 1'b1;
    end
    i_TX_Active = hold_active || (tx_cnt > 0);
  endtask

  task automatic step();
    model_edge();
    @(posedge i_Clock);
    #1;
    cyc++;
    check_outputs();
    tx_model();
  endtask

  task automatic set_hold(input bit v);
    hold_active = v;
    i_TX_Active = v || (tx_cnt > 0);
  endtask

  task automatic wait_idle(input string name, output bit done_before_fall);
    int n;
    n = 0;
    done_before_fall = 1'b0;
    while (o_Busy && n < 200) begin
      done_before_fall = i_TX_Done;
      step();
      n++;
    end
    chk(name, o_Busy, 0);
  endtask

  task automatic do_reset();
    i_Rst_L     = 1'b0;
    i_Req       = '0;
    hold_active = 1'b0;
    i_TX_Active = 1'b0;
    i_TX_Done   = 1'b0;
    model_reset();
    #1;
    chk("rst_ack", o_Ack, 0);
    chk("rst_dv", o_TX_DV, 0);
    chk("rst_byte", o_TX_Byte, 0);
    chk("rst_gid", o_Grant_Id, 0);
    chk("rst_busy", o_Busy, 0);
    @(negedge i_Clock);
    i_Rst_L = 1'b1;
  endtask

  initial begin
    bit         d;
    int         n;
    logic [7:0] exp_tx[$];

    tv[0] = '{4'b0100, 32'h44_33_22_11, 4'b0100, 2'd2, 8'h33};
    tv[1] = '{4'b1001, 32'h5A_00_00_3C, 4'b1000, 2'd3, 8'h5A};
    tv[2] = '{4'b0110, 32'h00_E1_7E_00, 4'b0010, 2'd1, 8'h7E};
    tv[3] = '{4'b0011, 32'h00_00_96_69, 4'b0001, 2'd0, 8'h69};
    tv[4] = '{4'b1111, 32'hF3_F2_F1_F0, 4'b0010, 2'd1, 8'hF1};
    tv[5] = '{4'b1000, 32'h81_00_00_00, 4'b1000, 2'd3, 8'h81};
    tv[6] = '{4'b0001, 32'h00_00_00_C3, 4'b0001, 2'd0, 8'hC3};

    checks = 0; errors = 0; cyc = 0;
    i_Rst_L = 1'b1; i_Req = '0; i_Req_Byte = '0;
    hold_active = 1'b0; i_TX_Active = 1'b0; i_TX_Done = 1'b0;
    #3;
    do_reset();

    // Table vectors: priority pointer carries over from one entry to the next.
    for (int t = 0; t < 7; t++) begin
      dv_log.delete();
      i_Req_Byte = tv[t].bytes;
      i_Req      = tv[t].req;
      step();
      chk("tv_ack", o_Ack, tv[t].exp_ack);
      chk("tv_gid", o_Grant_Id, tv[t].exp_gid);
      i_Req = '0;
      step();
      chk("tv_dv", o_TX_DV, 1);
      chk("tv_first_byte", o_TX_Byte, TAG ? (8'hA0 | 8'(tv[t].exp_gid)) : tv[t].exp_byte);
      wait_idle("tv_idle", d);
      if (dv_log.size() > 0) chk("tv_data_byte", dv_log[dv_log.size()-1], tv[t].exp_byte);
      chk("tv_dv_count", dv_log.size(), TAG ? 2 : 1);
    end

    // Single request with full latency and busy release on done.
    do_reset();
    dv_log.delete();
    i_Req_Byte = 32'h00_55_00_00;
    i_Req = 4'b0100;
    step();
    chk("single_ack", o_Ack, 4'b0100);
    i_Req = '0;
    step();
    chk("single_dv", o_TX_DV, 1);
    chk("single_byte", o_TX_Byte, TAG ? 8'hA2 : 8'h55);
    chk("single_gid", o_Grant_Id, 2);
    wait_idle("single_idle", d);
    chk("single_busy_on_done", d, 1);
    if (dv_log.size() > 0) chk("single_data", dv_log[dv_log.size()-1], 8'h55);

    // All four held from reset.
    do_reset();
    ack_log.delete(); dv_log.delete(); exp_tx.delete();
    i_Req_Byte = 32'h13_12_11_10;
    i_Req = 4'b1111;
    n = 0;
    while ((ack_log.size() < 4 || o_Busy) && n < 300) begin
      step();
      i_Req = i_Req & ~o_Ack;
      n++;
    end
    chk("all4_ack_count", ack_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (TAG) exp_tx.push_back(8'hA0 | 8'(i));
      exp_tx.push_back(8'h10 + 8'(i));
      if (i < ack_log.size()) chk("all4_order", ack_log[i], i);
    end
    chk("all4_tx_count", dv_log.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size(); i++)
      if (i < dv_log.size()) chk("all4_tx_seq", dv_log[i], exp_tx[i]);

    // Requesters 0 and 3 never drop their requests.
    do_reset();
    ack_log.delete();
    i_Req_Byte = 32'hD3_00_00_D0;
    i_Req = 4'b1001;
    n = 0;
    while (ack_log.size() < 4 && n < 300) begin
      step();
      n++;
    end
    i_Req = '0;
    wait_idle("fair_idle", d);
    chk("fair_ack_count", ack_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < ack_log.size()) chk("fair_order", ack_log[i], (i % 2 == 0) ? 0 : 3);

    // Transmitter busy in IDLE blocks grants.
    do_reset();
    i_Req_Byte = 32'h00_00_00_2B;
    set_hold(1'b1);
    i_Req = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("hold_no_ack", o_Ack, 0);
      chk("hold_no_dv", o_TX_DV, 0);
    end
    set_hold(1'b0);
    step();
    chk("hold_release_ack", o_Ack, 4'b0001);
    i_Req = '0;
    wait_idle("hold_idle", d);

    // Reset while waiting for the data byte to finish.
    do_reset();
    ack_log.delete();
    i_Req_Byte = 32'h00_77_00_00;
    i_Req = 4'b0100;
    step();
    i_Req = '0;
    step();
    step();
    chk("midrst_busy_before", o_Busy, 1);
    #2;
    do_reset();
    ack_log.delete();
    i_Req_Byte = 32'hB3_00_B1_00;
    i_Req = 4'b1010;
    step();
    chk("midrst_first_ack", o_Ack, 4'b0010);
    chk("midrst_first_gid", o_Grant_Id, 1);
    i_Req = '0;
    wait_idle("midrst_idle", d);
    chk("midrst_ack_count", ack_log.size(), 1);

`ifdef UART_TX_ARB_TAG_EN
    do_reset();
    ack_log.delete(); dv_log.delete();
    i_Req_Byte = 32'h00_00_C3_00;
    i_Req = 4'b0010;
    step();
    i_Req = '0;
    wait_idle("tag_idle", d);
    chk("tag_dv_count", dv_log.size(), 2);
    if (dv_log.size() == 2) begin
      chk("tag_byte0", dv_log[0], 8'hA1);
      chk("tag_byte1", dv_log[1], 8'hC3);
    end
    chk("tag_ack_count", ack_log.size(), 1);
`endif

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      set_hold($urandom_range(0, 9) == 0);
      step();
      for (int k = 0; k < N; k++) begin
        if (o_Ack[k]) i_Req[k] = 1'b0;
        else if (!i_Req[k] && $urandom_range(0, 3) == 0) begin
          i_Req_Byte[8*k +: 8] = 8'($urandom);
          i_Req[k] = 1'b1;
        end
      end
    end
    i_Req = '0;
    set_hold(1'b0);
    n = 0;
    while ((o_Busy || tx_cnt > 0) && n < 200) begin
      step();
      n++;
    end
    chk("rand_drain_busy", o_Busy, 0);
    chk("rand_queue_empty", m_txq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters; legal values 2..8.
REQ-002 Port i_Clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port i_Rst_L  input  1  asynchronous, active-low reset.
REQ-004 Port i_Req  input  NUM_REQ  per-requester byte-valid level; held high until acknowledged.
REQ-005 Port i_Req_Byte  input  8*NUM_REQ  packed bytes; requester k uses bits [8k+7:8k], stable while i_Req[k] is high.
REQ-006 Port o_Ack  output  NUM_REQ  one-cycle pulse; byte of requester k has been captured.
REQ-007 Port o_TX_DV  output  1  one-cycle load strobe to the UART transmitter.
REQ-008 Port o_TX_Byte  output  8  byte presented with o_TX_DV.
REQ-009 Port i_TX_Active  input  1  transmitter busy flag.
REQ-010 Port i_TX_Done  input  1  transmitter end-of-stop-bit pulse.
REQ-011 Port o_Grant_Id  output  $clog2(NUM_REQ)  index of the current or last granted requester.
REQ-012 Port o_Busy  output  1  high from grant until the final i_TX_Done of that transfer.

Function
REQ-013 States SHALL be IDLE, SEND_TAG, WAIT_TAG, SEND_DATA, WAIT_DATA; unused encodings SHALL return to IDLE.
REQ-014 In IDLE, with any i_Req bit high and i_TX_Active low, the block SHALL grant round-robin, starting the search at pointer r_Prio and wrapping at NUM_REQ-1 -> 0.
REQ-015 On the grant edge the block SHALL latch the byte, set o_Grant_Id, set o_Busy, pulse o_Ack[k] for exactly the next cycle, and set r_Prio = (k+1) mod NUM_REQ.
REQ-016 In IDLE, while i_TX_Active is high, the block SHALL issue no grant; pending requests wait.
REQ-017 In SEND_DATA, o_TX_DV SHALL be high for exactly one cycle with o_TX_Byte = latched byte; the next state is WAIT_DATA.
REQ-018 In WAIT_DATA, the block SHALL ignore i_Req; on i_TX_Done high it SHALL return to IDLE and clear o_Busy on the same edge.
REQ-019 Latency SHALL be: i_Req sampled in IDLE at edge N -> o_Ack high in cycle N+1 -> o_TX_DV high in cycle N+2 (untagged).
REQ-020 i_Req high during the o_Ack cycle SHALL NOT cause a second grant, because the block is not in IDLE.
REQ-021 o_TX_DV and o_Ack SHALL never be high for two consecutive cycles.
REQ-022 At most one o_Ack bit SHALL be high in any cycle.

Reset
REQ-023 When i_Rst_L is low, the block SHALL asynchronously force: state IDLE, o_Ack 0, o_TX_DV 0, o_TX_Byte 0x00, o_Grant_Id 0, o_Busy 0, r_Prio 0.
REQ-024 Reset mid-transfer SHALL discard the latched byte without re-acknowledging it; the first grant after reset goes to the lowest requesting index.

Configuration
REQ-025 Macro UART_TX_ARB_TAG_EN SHALL control tagging of each granted byte.
REQ-026 With UART_TX_ARB_TAG_EN defined, a grant SHALL go IDLE -> SEND_TAG (o_TX_DV, byte 0xA0 | k) -> WAIT_TAG (until i_TX_Done) -> SEND_DATA -> WAIT_DATA; one o_Ack per grant.
REQ-027 Without UART_TX_ARB_TAG_EN, SEND_TAG and WAIT_TAG SHALL be absent and a grant SHALL go IDLE -> SEND_DATA.

Verification
REQ-028 Single request: i_Req = 4'b0100, byte2 = 0x55 -> o_Ack = 4'b0100 one cycle later; then o_TX_DV one cycle with 0x55, o_Grant_Id = 2; o_Busy falls on i_TX_Done.
REQ-029 All four requests held after reset, bytes 0x10/0x11/0x12/0x13 -> grants 0,1,2,3 in order; TX sequence 0x10,0x11,0x12,0x13; each o_Ack exactly once.
REQ-030 Requester 0 re-requests immediately after each ack while requester 3 holds -> grant order 0,3,0,3; no starvation.
REQ-031 i_TX_Active high in IDLE with i_Req = 4'b0001 -> no o_Ack or o_TX_DV until i_TX_Active falls; then grant on the next edge.
REQ-032 i_Rst_L pulsed low during WAIT_DATA -> all outputs at reset values immediately; after release, requests 4'b1010 -> first grant to 1.
REQ-033 UART_TX_ARB_TAG_EN defined, requester 1 byte 0xC3 -> o_TX_DV pulses carry 0xA1 then 0xC3 (second only after i_TX_Done); single o_Ack[1].
